// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and a
// constant clog2 helper used for index widths.
package fifo_arb_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic LOCK = 1'b1;

  typedef enum logic {
    StIdle = IDLE,
    StLock = LOCK
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: returns a one-hot winner, searching from last_i+1
// upward (wrapping) for the first asserted request.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  output logic [NREQ-1:0] win_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a FIFO. Define FIFO_WR_ARB_BURST_EN to
// compile in burst locking (up to BURST beats per grant); otherwise per-beat RR.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned BURST  = 4,
  localparam int unsigned OwW   = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_data_in,
  output logic [OwW-1:0]         owner,
  output logic                   locked
);

  logic [OwW-1:0]  last_q, last_d, owner_q, owner_d, gnt_idx;
  logic [NREQ-1:0] rr_win, owner_mask;
  logic            lock_st;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (OwW)
  ) u_rr_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (rr_win)
  );

  // Reset and a full FIFO both block every grant, locked or not.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    gnt                 = '0;
    if (rst_n && !fifo_full) begin
      gnt = lock_st ? (req & owner_mask) : rr_win;
    end
  end

  always_comb begin
    fifo_wr_en   = |(req & gnt);
    fifo_data_in = '0;
    gnt_idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        fifo_data_in = req_data[i*DWIDTH +: DWIDTH];
        gnt_idx      = OwW'(i);
      end
    end
  end

`ifdef FIFO_WR_ARB_BURST_EN
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  assign lock_st = (state_q == StLock);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (fifo_wr_en) begin
          last_d  = gnt_idx;
          owner_d = gnt_idx;
          if (BURST > 1) begin
            state_d = StLock;
            cnt_d   = 8'd1;
          end
        end
      end
      StLock: begin
        // Owner withdrawing ends the burst early; no one else is served this cycle.
        if (!req[owner_q]) begin
          state_d = StIdle;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (fifo_wr_en) begin
          if (cnt_q == 8'(BURST - 1)) begin
            state_d = StIdle;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_burst;

  assign lock_st      = 1'b0;
  assign unused_burst = ^BURST;

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    if (fifo_wr_en) begin
      last_d  = gnt_idx;
      owner_d = gnt_idx;
    end
  end
`endif

  // last starts at NREQ-1 so requester 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= OwW'(NREQ - 1);
      owner_q <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  assign owner  = owner_q;
  assign locked = lock_st;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: reference model of the arbitration rules plus a
// depth-4 FIFO model fed from the DUT's write port.
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int Burst = 4;
  localparam int Depth = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam bit BurstOn = 1'b1;
`else
  localparam bit BurstOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  owner;
  logic        locked;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NREQ   (N),
    .DWIDTH (8),
    .BURST  (Burst)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .locked       (locked)
  );

  int         vectors = 0;
  int         fails = 0;
  logic [7:0] fifo_q[$];
  logic       rd;
  int         m_last, m_lock, m_beats, m_owner;
  logic [3:0] last_eg, dut_gnt;
  int         wr_count = 0;
  logic [7:0] dat[4];
  logic [3:0] rv;
  logic [3:0] seq[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Grant the rules call for, given the model's arbitration history.
  function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic full,
                                           input logic rn);
    logic [3:0] g;
    g = '0;
    if (!rn || full) return g;
    if (m_lock >= 0) begin
      g[m_lock] = r[m_lock];
      return g;
    end
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (r[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(input logic [3:0] eg);
    int w;
    w = 0;
    for (int i = 0; i < N; i++) if (eg[i]) w = i;
    if (!rst_n) begin
      m_last = N - 1; m_lock = -1; m_beats = 0; m_owner = 0;
    end else if (m_lock >= 0) begin
      if (!req[m_lock]) begin
        m_last = m_lock; m_lock = -1;
      end else if (eg != 0) begin
        m_beats++;
        if (m_beats == Burst) begin
          m_last = m_lock; m_lock = -1;
        end
      end
    end else if (eg != 0) begin
      m_last = w; m_owner = w;
      if (BurstOn && Burst > 1) begin
        m_lock = w; m_beats = 1;
      end
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    logic [7:0] ed, wd;
    logic       wr;
    @(negedge clk);
    eg = model_gnt(req, fifo_full, rst_n);
    ed = '0;
    for (int i = 0; i < N; i++) if (eg[i]) ed = req_data[i*8 +: 8];
    dut_gnt = gnt;
    wr      = fifo_wr_en;
    wd      = fifo_data_in;
    check("gnt", 32'(gnt), 32'(eg));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(|eg));
    check("fifo_data_in", 32'(fifo_data_in), 32'(ed));
    check("owner", 32'(owner), 32'(m_owner));
    check("locked", 32'(locked), 32'(m_lock >= 0));
    @(posedge clk);
    model_edge(eg);
    last_eg = eg;
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (wr) begin
      fifo_q.push_back(wd);
      wr_count++;
    end
    #1;
    fifo_full = (fifo_q.size() >= Depth);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rd    = 1'b0;
    step();
    fifo_q.delete();
    fifo_full = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0; rd = 1'b0;
    m_last = N - 1; m_lock = -1; m_beats = 0; m_owner = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single request from requester 0 lands in the FIFO.
    req = 4'b0001; req_data = 32'h0000_00A5;
    step();
    check("fifo_level_a5", 32'(fifo_q.size()), 32'd1);
    check("fifo_head_a5", 32'(fifo_q[0]), 32'h0000_00A5);

    // Sustained requests: bursts when locking is built in, otherwise rotation.
    do_reset();
    rd = 1'b1;
    if (BurstOn) begin
      req = 4'b0011; req_data = 32'h0000_2211;
      seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    end else begin
      req = 4'b1111; req_data = 32'h4433_2211;
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_sequence", 32'(dut_gnt), 32'(seq[i]));
    end

    // Fill the FIFO, stall while full, one read frees exactly one beat.
    do_reset();
    rd = 1'b0; req = 4'b0001; req_data = 32'h0000_0010;
    wr_count = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (last_eg != 0) req_data[7:0] = req_data[7:0] + 8'd1;
    end
    check("writes_until_full", 32'(wr_count), 32'd4);
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
    step();
    check("writes_after_one_read", 32'(wr_count), 32'd5);
    check("fifo_level_full", 32'(fifo_q.size()), 32'd4);

    // Owner withdraws after two beats; the next requester in rotation follows.
    do_reset();
    rd = 1'b1; req = 4'b0111; req_data = 32'h0033_2211;
    step();
    step();
    req = 4'b0110;
    step();
    check("drop_cycle_gnt", 32'(dut_gnt), BurstOn ? 32'd0 : 32'b0100);
    step();
    check("after_drop_gnt", 32'(dut_gnt), 32'b0010);

    // Reset in the middle of a burst abandons it.
    do_reset();
    rd = 1'b1; req = 4'b0001; req_data = 32'h7700_0055;
    step();
    step();
    rst_n = 1'b0; req = 4'b1000;
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_gnt", 32'(dut_gnt), 32'b1000);

    // Random traffic; requesters hold their data until served.
    do_reset();
    rv = '0;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(63) != 0);
      rd    = ($urandom_range(1) == 1);
      req   = rv;
      for (int i = 0; i < N; i++) req_data[i*8 +: 8] = dat[i];
      step();
      for (int i = 0; i < N; i++) begin
        if (last_eg[i]) begin
          rv[i]  = 1'($urandom_range(1));
          dat[i] = 8'($urandom);
        end else if (rv[i] && $urandom_range(7) == 0) begin
          rv[i] = 1'b0;
        end else if (!rv[i] && $urandom_range(1) == 1) begin
          rv[i]  = 1'b1;
          dat[i] = 8'($urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
